// File: rtl/system_onchip_memory_pipelined.sv
// Single-port on-chip RAM with an Avalon-MM slave port, a 1- or 2-stage read pipeline,
// waitrequest back-pressure driven by clken, and an optional post-reset zero-fill engine.
module system_onchip_memory_pipelined #(
    parameter int DATA_W         = 32,
    parameter int DEPTH          = 8192,
    parameter int ADDR_W         = 13,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    input  logic                  clken,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    output logic                  init_busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [IDX_W-1:0]    idx;
    logic                in_range;
    logic                accept;
    logic                wr_acc;
    logic                rd_acc;
    logic                rd_v1;
    logic [DATA_W-1:0]   rd_q;

    assign idx      = address[IDX_W-1:0];
    assign in_range = ({1'b0, address} < (ADDR_W + 1)'(DEPTH));
    assign accept   = clken & (state == ST_IDLE) & chipselect & (read | write);
    assign wr_acc   = accept & write;
    // A combined read+write performs the write and drops the read.
    assign rd_acc   = accept & read & ~write;

    assign init_busy   = (state == ST_INIT);
    assign waitrequest = ~reset_n | (state != ST_IDLE) | ~clken;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_IDLE;
            clr_cnt <= '0;
        end else if (clken && state == ST_INIT) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == IDX_W'(DEPTH - 1)) begin
                state <= ST_IDLE;
            end
        end
    end

    // RAM array: zero-fill while initialising, byte-masked writes otherwise.
    always_ff @(posedge clk) begin
        if (clken && state == ST_INIT) begin
            mem[clr_cnt] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (byteenable[i]) begin
                    mem[idx][8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    // First read stage: synchronous RAM read, out-of-range reads return zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_v1 <= 1'b0;
            rd_q  <= '0;
        end else if (clken) begin
            rd_v1 <= rd_acc;
            if (rd_acc) begin
                rd_q <= in_range ? mem[idx] : '0;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic rd_v2;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_v2    <= 1'b0;
                    readdata <= '0;
                end else if (clken) begin
                    rd_v2 <= rd_v1;
                    if (rd_v1) begin
                        readdata <= rd_q;
                    end
                end
            end

            assign readdatavalid = rd_v2 & clken;
        end else begin : g_lat1
            assign readdata      = rd_q;
            assign readdatavalid = rd_v1 & clken;
        end
    endgenerate

endmodule
